fetch_decode_unit: RTL

- Producer side of the control FSM's instruction interface.
- Owns the PC and the instruction register (IR). It fetches instruction words from memory through a req/valid handshake and presents the opcode and decoded fields to the control FSM.
- Applies the control FSM's PCSource selection: 00 increment, 01 branch, 10 jump, 11 hold.
- Sits between the control FSM, the ALU (branch condition) and the unified memory port.

---
 rtl/fetch_decode_unit_pkg.sv | 35 +++
 rtl/fetch_decode_unit_if.sv | 13 +
 rtl/fetch_decode_unit_next_pc_calc.sv | 32 +++
 rtl/fetch_decode_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/fetch_decode_unit_pkg.sv
// Shared definitions for the fetch/decode unit and the control FSM that consumes it.
// Covers PC source encodings, opcodes, IR field positions and the fetch state enum.
package fetch_decode_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PCS_INC  = 2'b00;
  localparam logic [1:0] PCS_BR   = 2'b01;
  localparam logic [1:0] PCS_JMP  = 2'b10;
  localparam logic [1:0] PCS_HOLD = 2'b11;

  localparam logic [5:0] OP_NOOP = 6'b000000;
  localparam logic [5:0] OP_JUMP = 6'b000001;
  localparam logic [5:0] OP_JAL  = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b100000;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned RS_LSB  = 16;
  localparam int unsigned RS_W    = 5;
  localparam int unsigned RT_LSB  = 11;
  localparam int unsigned RT_W    = 5;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JT_W    = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Unified memory read port used for instruction fetch.
// The master drives the request side, the slave returns the read data.
interface fetch_decode_unit_if;
  import fetch_decode_unit_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_rvalid, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_rvalid, output mem_rdata);
endinterface

// File: rtl/fetch_decode_unit_next_pc_calc.sv
// Combinational next-PC selection: increment, branch, jump or hold.
// Shared by the PC register and the IDLE-cycle fetch address forwarding path.
module fetch_decode_unit_next_pc_calc
  import fetch_decode_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [JT_W-1:0] target,
  input  logic            pc_update,
  input  logic [1:0]      pc_source,
  input  logic            branch_taken,
  output logic [XLEN-1:0] pc_next_c
);

  logic [XLEN-1:0] pc4_c;
  logic [XLEN-1:0] br_off_c;

  assign pc4_c    = pc + XLEN'(4);
  assign br_off_c = {{(XLEN-IMM_W-2){target[IMM_W-1]}}, target[IMM_W-1:0], 2'b00};

  always_comb begin
    pc_next_c = pc;
    if (pc_update) begin
      case (pc_source)
        PCS_INC:  pc_next_c = pc4_c;
        PCS_BR:   pc_next_c = branch_taken ? (pc4_c + br_off_c) : pc4_c;
        PCS_JMP:  pc_next_c = {pc4_c[XLEN-1:XLEN-4], target, 2'b00};
        PCS_HOLD: pc_next_c = pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction fetch and decode front end: owns PC and IR, fetches over a req/rvalid
// handshake with a bounded wait, and exposes the decoded IR fields to control.
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_req,
  input  logic                   pc_update,
  input  logic [1:0]             pc_source,
  input  logic                   branch_taken,
  fetch_decode_unit_if.master    mem,
  output logic [XLEN-1:0]        pc,
  output logic [OPC_W-1:0]       opcode,
  output logic [RD_W-1:0]        rd,
  output logic [RS_W-1:0]        rs,
  output logic [RT_W-1:0]        rt,
  output logic [IMM_W-1:0]       imm,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   fetch_err
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  fetch_state_t     state, state_next;
  logic [XLEN-1:0]  ir;
  logic [XLEN-1:0]  pc_next_c;
  logic [CNT_W-1:0] wait_cnt, cnt_next;
  logic             req_next, addr_load, ir_load, timeout;

  fetch_decode_unit_next_pc_calc u_next_pc (
    .pc           (pc),
    .target       (ir[JT_W-1:0]),
    .pc_update    (pc_update),
    .pc_source    (pc_source),
    .branch_taken (branch_taken),
    .pc_next_c    (pc_next_c)
  );

  assign opcode = ir[OPC_LSB +: OPC_W];
  assign rd     = ir[RD_LSB  +: RD_W];
  assign rs     = ir[RS_LSB  +: RS_W];
  assign rt     = ir[RT_LSB  +: RT_W];
  assign imm    = ir[IMM_LSB +: IMM_W];

  // Fetch FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = wait_cnt;
    req_next   = 1'b0;
    addr_load  = 1'b0;
    ir_load    = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (fetch_req) begin
          state_next = ST_REQ;
          req_next   = 1'b1;
          addr_load  = 1'b1;
        end
      end
      ST_REQ: begin
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          ir_load    = 1'b1;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          timeout    = 1'b1;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = wait_cnt + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // PC, IR and registered handshake/status outputs; the fetch address uses the forwarded next PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      ir           <= {OP_NOOP, (XLEN-OPC_W)'(0)};
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      instr_valid  <= 1'b0;
      busy         <= 1'b0;
      fetch_err    <= 1'b0;
    end else begin
      pc           <= pc_next_c;
      mem.mem_req  <= req_next;
      instr_valid  <= ir_load;
      busy         <= (state_next != ST_IDLE);
      fetch_err    <= fetch_err | timeout;
      if (addr_load) mem.mem_addr <= pc_next_c;
      if (ir_load)   ir <= mem.mem_rdata;
    end
  end

endmodule
